// File: rtl/avalon_onchip_ram_burst.sv
// ============================================================================
// Module   : avalon_onchip_ram_burst
// Brief    : Single-clock Avalon-MM on-chip RAM slave with burst read/write,
//            byte enables, global clock enable and address wrap at DEPTH.
// Options  : define ONCHIP_RAM_OUTREG_EN to add an output register stage
//            (read latency 2 instead of 1).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module avalon_onchip_ram_burst #(
  parameter int DATA_WIDTH  = 32,
  parameter int DEPTH       = 15000,
  parameter int ADDR_WIDTH  = 14,
  parameter int BURST_WIDTH = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      chipselect,
  input  logic                      read,
  input  logic                      write,
  input  logic [ADDR_WIDTH-1:0]     address,
  input  logic [DATA_WIDTH/8-1:0]   byteenable,
  input  logic [DATA_WIDTH-1:0]     writedata,
  input  logic [BURST_WIDTH-1:0]    burstcount,
  input  logic                      clken,
  output logic                      waitrequest,
  output logic [DATA_WIDTH-1:0]     readdata,
  output logic                      readdatavalid
);

  localparam int c_num_bytes = DATA_WIDTH / 8;

  localparam logic [1:0] c_st_idle     = 2'd0;
  localparam logic [1:0] c_st_wr_burst = 2'd1;
  localparam logic [1:0] c_st_rd_burst = 2'd2;

  localparam logic [ADDR_WIDTH:0]    c_depth     = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH-1:0]  c_last_addr = ADDR_WIDTH'(DEPTH - 1);
  localparam logic [ADDR_WIDTH-1:0]  c_addr_one  = ADDR_WIDTH'(1);
  localparam logic [BURST_WIDTH-1:0] c_one       = BURST_WIDTH'(1);

  logic [DATA_WIDTH-1:0]  r_mem [0:DEPTH-1];

  logic [1:0]             r_state;
  logic [1:0]             w_next_state;
  logic [BURST_WIDTH-1:0] r_beat_cnt;   // beats still to go after the current one
  logic [ADDR_WIDTH-1:0]  r_cur_addr;   // address of the next burst beat

  logic [BURST_WIDTH-1:0] w_burst_len;
  logic                   w_burst_multi;
  logic [ADDR_WIDTH-1:0]  w_mem_addr;
  logic [ADDR_WIDTH-1:0]  w_next_addr;
  logic                   w_addr_ok;
  logic                   w_wr_start;
  logic                   w_rd_start;
  logic                   w_wr_en;
  logic                   w_rd_en;

  logic [DATA_WIDTH-1:0]  r_rd_data;
  logic                   r_rd_valid;

  // A burstcount of zero is treated as a single beat.
  assign w_burst_len   = (burstcount == '0) ? c_one : burstcount;
  assign w_burst_multi = (w_burst_len != c_one);

  // Beat address advances by one and wraps from the last word back to 0;
  // out-of-range start addresses simply count upward.
  assign w_next_addr = (w_mem_addr == c_last_addr) ? '0 : (w_mem_addr + c_addr_one);
  assign w_addr_ok   = ({1'b0, w_mem_addr} < c_depth);

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= c_st_idle;
    end else if (clken) begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic: bursts of more than one beat leave IDLE; the last beat returns.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      c_st_idle: begin
        if (w_wr_start && w_burst_multi) begin
          w_next_state = c_st_wr_burst;
        end else if (w_rd_start && w_burst_multi) begin
          w_next_state = c_st_rd_burst;
        end
      end
      c_st_wr_burst: begin
        if (w_wr_en && (r_beat_cnt == c_one)) begin
          w_next_state = c_st_idle;
        end
      end
      c_st_rd_burst: begin
        if (r_beat_cnt == c_one) begin
          w_next_state = c_st_idle;
        end
      end
      default: w_next_state = c_st_idle;
    endcase
  end

  // Output/control decode: handshake, array enables and the address being accessed.
  always_comb begin
    waitrequest = ~reset & (~clken | (r_state == c_st_rd_burst));
    w_mem_addr  = (r_state == c_st_idle) ? address : r_cur_addr;
    w_wr_start  = 1'b0;
    w_rd_start  = 1'b0;
    w_wr_en     = 1'b0;
    w_rd_en     = 1'b0;
    case (r_state)
      c_st_idle: begin
        // Write wins when read and write are both asserted.
        w_wr_start = clken & chipselect & write;
        w_rd_start = clken & chipselect & read & ~write;
        w_wr_en    = w_wr_start;
        w_rd_en    = w_rd_start;
      end
      c_st_wr_burst: begin
        // Reads are ignored here; master may idle between write beats.
        w_wr_en = clken & chipselect & write;
      end
      c_st_rd_burst: begin
        w_rd_en = clken;
      end
      default: begin
        w_wr_en = 1'b0;
      end
    endcase
  end

  // Beat counter and running burst address.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_beat_cnt <= '0;
      r_cur_addr <= '0;
    end else if (clken) begin
      if (w_wr_start || w_rd_start) begin
        r_beat_cnt <= w_burst_len - c_one;
        r_cur_addr <= w_next_addr;
      end else if (w_wr_en || w_rd_en) begin
        r_beat_cnt <= r_beat_cnt - c_one;
        r_cur_addr <= w_next_addr;
      end
    end
  end

  // Byte-enabled array write; beats outside the array are dropped. Not reset.
  always_ff @(posedge clk) begin
    if (w_wr_en && w_addr_ok) begin
      for (int b = 0; b < c_num_bytes; b++) begin
        if (byteenable[b]) begin
          r_mem[w_mem_addr][b*8 +: 8] <= writedata[b*8 +: 8];
        end
      end
    end
  end

  // Array read stage; out-of-range beats return zero but still count as valid.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rd_data  <= '0;
      r_rd_valid <= 1'b0;
    end else if (clken) begin
      r_rd_valid <= w_rd_en;
      if (w_rd_en) begin
        r_rd_data <= w_addr_ok ? r_mem[w_mem_addr] : '0;
      end
    end
  end

`ifdef ONCHIP_RAM_OUTREG_EN
  logic [DATA_WIDTH-1:0] r_out_data;
  logic                  r_out_valid;

  // Extra output register stage, frozen together with the rest of the pipe.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
    end else if (clken) begin
      r_out_data  <= r_rd_data;
      r_out_valid <= r_rd_valid;
    end
  end

  assign readdata      = r_out_data;
  assign readdatavalid = r_out_valid & clken;
`else
  assign readdata      = r_rd_data;
  assign readdatavalid = r_rd_valid & clken;
`endif

endmodule

`default_nettype wire

// File: tb/tb_avalon_onchip_ram_burst.sv
// ============================================================================
// Module   : tb_avalon_onchip_ram_burst
// Brief    : Self-checking bench for avalon_onchip_ram_burst: table of single
//            read/write vectors plus hand-written burst, wrap, out-of-range,
//            clock-enable and mid-burst reset sequences.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_avalon_onchip_ram_burst;

`ifdef ONCHIP_RAM_OUTREG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic        clk;
  logic        reset;
  logic        chipselect;
  logic        read;
  logic        write;
  logic [13:0] address;
  logic [3:0]  byteenable;
  logic [31:0] writedata;
  logic [3:0]  burstcount;
  logic        clken;
  logic        waitrequest;
  logic [31:0] readdata;
  logic        readdatavalid;

  avalon_onchip_ram_burst dut (
    .clk           (clk),
    .reset         (reset),
    .chipselect    (chipselect),
    .read          (read),
    .write         (write),
    .address       (address),
    .byteenable    (byteenable),
    .writedata     (writedata),
    .burstcount    (burstcount),
    .clken         (clken),
    .waitrequest   (waitrequest),
    .readdata      (readdata),
    .readdatavalid (readdatavalid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // op: 0 = write, 1 = single read (expect data), 2 = read+write together
  typedef struct {
    logic [1:0]  op;
    logic [13:0] addr;
    logic [3:0]  be;
    logic [31:0] data;
    logic [31:0] exp;
  } vec_t;

  vec_t        vecs [10];
  int          n_checks;
  int          n_fail;
  logic [31:0] got [32];
  int          nbeats;
  int          first_k;
  int          last_k;
  int          wait_hi;
  int          frozen_valid;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_bus();
    chipselect = 1'b0;
    read       = 1'b0;
    write      = 1'b0;
    burstcount = 4'd1;
    byteenable = 4'h0;
    writedata  = 32'h0;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic single_write(input logic [13:0] a, input logic [3:0] be, input logic [31:0] d);
    chipselect = 1'b1; write = 1'b1; read = 1'b0;
    address = a; byteenable = be; writedata = d; burstcount = 4'd1;
    step();
    idle_bus();
  endtask

  // Single-beat read; returns the data/valid seen LAT cycles after acceptance.
  task automatic single_read(input logic [13:0] a, output logic [31:0] d, output logic v);
    chipselect = 1'b1; read = 1'b1; write = 1'b0;
    address = a; burstcount = 4'd1;
    step();
    idle_bus();
    for (int i = 1; i < LAT; i++) step();
    v = readdatavalid;
    d = readdata;
  endtask

  // Write burst; one idle cycle is inserted after beat 1 to exercise hold.
  task automatic write_burst(input logic [13:0] a, input int n, input logic [31:0] base);
    for (int i = 0; i < n; i++) begin
      chipselect = 1'b1; write = 1'b1; read = 1'b0;
      byteenable = 4'hF; writedata = base + 32'(i);
      address    = (i == 0) ? a : 14'h0;
      burstcount = (i == 0) ? 4'(n) : 4'd0;
      step();
      if (i == 1) begin
        idle_bus();
        step();
      end
    end
    idle_bus();
  endtask

  // Issue a read burst and collect beats over a bounded window; clken is
  // dropped for two cycles starting at freeze_at (if >= 0).
  task automatic run_read(input logic [13:0] a, input int n, input int freeze_at);
    chipselect = 1'b1; read = 1'b1; write = 1'b0;
    address = a; burstcount = 4'(n);
    step();
    idle_bus();
    nbeats = 0; first_k = -1; last_k = -1; wait_hi = 0; frozen_valid = 0;
    for (int k = 0; k < 30; k++) begin
      clken = !(freeze_at >= 0 && (k == freeze_at || k == freeze_at + 1));
      #1;
      if (waitrequest) wait_hi++;
      if (readdatavalid) begin
        if (!clken) frozen_valid++;
        if (nbeats < 32) got[nbeats] = readdata;
        nbeats++;
        if (first_k < 0) first_k = k;
        last_k = k;
      end
      step();
    end
    clken = 1'b1;
  endtask

  initial begin
    logic [31:0] d;
    logic        v;
    int          cnt;

    n_checks = 0;
    n_fail   = 0;
    idle_bus();
    address = '0;
    clken   = 1'b1;
    reset   = 1'b1;

    vecs[0] = '{2'd0, 14'd5,   4'hF, 32'hDEADBEEF, 32'h0};
    vecs[1] = '{2'd1, 14'd5,   4'h0, 32'h0,        32'hDEADBEEF};
    vecs[2] = '{2'd0, 14'd7,   4'hF, 32'hFFFFFFFF, 32'h0};
    vecs[3] = '{2'd0, 14'd7,   4'h5, 32'h00000000, 32'h0};
    vecs[4] = '{2'd1, 14'd7,   4'h0, 32'h0,        32'hFF00FF00};
    vecs[5] = '{2'd2, 14'd9,   4'hF, 32'h11223344, 32'h0};
    vecs[6] = '{2'd1, 14'd9,   4'h0, 32'h0,        32'h11223344};
    vecs[7] = '{2'd0, 14'd100, 4'hF, 32'hAAAAAAAA, 32'h0};
    vecs[8] = '{2'd0, 14'd100, 4'hC, 32'h55550000, 32'h0};
    vecs[9] = '{2'd1, 14'd100, 4'h0, 32'h0,        32'h5555AAAA};

    step();
    check("reset_waitrequest",   32'(waitrequest),   32'd0);
    check("reset_readdatavalid", 32'(readdatavalid), 32'd0);
    check("reset_readdata",      readdata,           32'd0);
    step();
    reset = 1'b0;
    step();

    // Table of single-beat transactions, issued back to back.
    for (int i = 0; i < 10; i++) begin
      case (vecs[i].op)
        2'd0: single_write(vecs[i].addr, vecs[i].be, vecs[i].data);
        2'd1: begin
          single_read(vecs[i].addr, d, v);
          check($sformatf("vec%0d_valid", i), 32'(v), 32'd1);
          check($sformatf("vec%0d_data", i), d, vecs[i].exp);
        end
        default: begin
          chipselect = 1'b1; read = 1'b1; write = 1'b1;
          address = vecs[i].addr; byteenable = vecs[i].be;
          writedata = vecs[i].data; burstcount = 4'd1;
          step();
          idle_bus();
          for (int j = 1; j < LAT; j++) step();
          check($sformatf("vec%0d_rw_no_valid", i), 32'(readdatavalid), 32'd0);
        end
      endcase
    end

    // Write burst crossing the top of the array, then read it back.
    write_burst(14'd14998, 4, 32'd1);
    run_read(14'd14998, 4, -1);
    check("wrap_beats", 32'(nbeats), 32'd4);
    for (int i = 0; i < 4; i++) check($sformatf("wrap_beat%0d", i), got[i], 32'(i + 1));
    check("wrap_waitrequest_cycles", 32'(wait_hi), 32'd3);
    check("wrap_first_beat", 32'(first_k), 32'(LAT - 1));
    check("wrap_contiguous", 32'(last_k - first_k + 1), 32'd4);
    single_read(14'd0, d, v);
    check("wrap_word0", d, 32'd3);
    single_read(14'd1, d, v);
    check("wrap_word1", d, 32'd4);

    // Out-of-range read burst returns zero beats.
    run_read(14'd15500, 3, -1);
    check("oor_beats", 32'(nbeats), 32'd3);
    for (int i = 0; i < 3; i++) check($sformatf("oor_beat%0d", i), got[i], 32'd0);
    single_read(14'd0, d, v);
    check("oor_word0_unchanged", d, 32'd3);

    // Read burst stretched by two cycles of clken=0.
    write_burst(14'd0, 8, 32'h100);
    run_read(14'd0, 8, 3);
    check("freeze_beats", 32'(nbeats), 32'd8);
    check("freeze_no_valid_when_frozen", 32'(frozen_valid), 32'd0);
    check("freeze_span", 32'(last_k - first_k + 1), 32'd10);
    for (int i = 0; i < 8; i++) check($sformatf("freeze_beat%0d", i), got[i], 32'h100 + 32'(i));
    clken = 1'b0;
    #1;
    check("freeze_waitrequest", 32'(waitrequest), 32'd1);
    clken = 1'b1;
    step();

    // Reset pulsed mid read burst after three beats have been seen.
    chipselect = 1'b1; read = 1'b1; write = 1'b0;
    address = 14'd0; burstcount = 4'd8;
    step();
    idle_bus();
    cnt = 0;
    for (int k = 0; k < 20 && cnt < 3; k++) begin
      if (readdatavalid) cnt++;
      if (cnt < 3) step();
    end
    check("rst_beats_before", 32'(cnt), 32'd3);
    #2;
    reset = 1'b1;
    #1;
    check("rst_readdatavalid", 32'(readdatavalid), 32'd0);
    check("rst_waitrequest",   32'(waitrequest),   32'd0);
    check("rst_readdata",      readdata,           32'd0);
    step();
    step();
    reset = 1'b0;
    cnt = 0;
    for (int k = 0; k < 10; k++) begin
      if (readdatavalid) cnt++;
      step();
    end
    check("rst_no_valid_after", 32'(cnt), 32'd0);
    single_read(14'd3, d, v);
    check("rst_mem_kept_valid", 32'(v), 32'd1);
    check("rst_mem_kept_data", d, 32'h103);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
